alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; shift amount is the low log2(WIDTH) bits of b.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port alu_control  input  4  operation select.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  high when result == 0.

Function
REQ-013 SHALL encode alu_control: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT (signed), 8 SRA, 9 MUL, 12 NOR; any other code yields result 0.
REQ-014 SHALL implement FSM states IDLE, SHIFT, MUL, DONE.
REQ-015 SHALL assert in_ready only in IDLE; a request is accepted on a cycle with in_valid && in_ready, and a, b, alu_control are registered at acceptance.
REQ-016 SHALL, for AND/OR/ADD/XOR/SUB/SLT/NOR/undefined codes, go IDLE->DONE with out_valid high on the cycle after acceptance (latency 1).
REQ-017 SHALL, for SLL/SRL/SRA, shift one bit per cycle in SHIFT for exactly shamt cycles, then enter DONE (latency 1 + shamt); shamt == 0 goes directly to DONE.
REQ-018 SHALL, for MUL (when compiled in), perform shift-add over WIDTH cycles in MUL and enter DONE (latency WIDTH + 1); result is the low WIDTH bits of the product.
REQ-019 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH, with no overflow flag.
REQ-020 SHALL make SLT return 1 when $signed(a) < $signed(b), else 0, including a = most-negative value.
REQ-021 SHALL hold out_valid, result and zero stable in DONE until out_ready is high, then return to IDLE on the next edge.
REQ-022 SHALL keep in_ready low in DONE; a request arriving alongside out_ready in DONE is accepted on the first IDLE cycle, one cycle later.
REQ-023 SHALL keep result and zero at their last value outside DONE; out_valid is high only in DONE.
REQ-024 SHALL ignore in_valid and input changes while in SHIFT, MUL or DONE.

Reset
REQ-025 SHALL, on rst_n low, immediately enter IDLE with out_valid = 0, result = 0, zero = 1, in_ready = 1 after release, and iteration counter = 0.
REQ-026 SHALL, on reset mid-operation (SHIFT/MUL/DONE), discard the operation with no result delivered.

Configuration
REQ-027 SHALL compile MUL support only when macro ALU_SEQ_MUL_EN is defined; without it, code 9 behaves as an undefined code (result 0, latency 1) and no MUL state or multiplier datapath exists.

Verification
REQ-028 SHALL check ADD a=7, b=5, out_ready=1 -> out_valid exactly 1 cycle after acceptance, result=12, zero=0.
REQ-029 SHALL check SUB a=5, b=5 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> result=1.
REQ-030 SHALL check SRA a=0x80000000, b=4 -> out_valid 5 cycles after acceptance, result=0xF8000000; SLL with b=0 -> latency 1, result=a.
REQ-031 SHALL check backpressure: out_ready low for 3 cycles in DONE -> result stable and in_ready=0 throughout, IDLE one edge after out_ready rises.
REQ-032 SHALL check MUL 0xFFFF x 0x10001 with ALU_SEQ_MUL_EN -> result=0xFFFFFFFF after 33 cycles; without the macro -> result=0 after 1 cycle.
REQ-033 SHALL check rst_n pulsed low during SHIFT with b=20 -> out_valid never asserts, in_ready=1 after release, and the next ADD completes correctly.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake: logic ops finish in one cycle, shifts take one cycle per bit.
// The shift-add multiplier (code 9) is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // SHIFT | shifting acc by one bit per cycle, cnt counts remaining bits
    // MUL   | one shift-add step per cycle, cnt counts remaining steps
    // DONE  | result presented, waiting for out_ready

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] S_MUL   = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif
    localparam logic [3:0] OP_NOR = 4'd12;

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [CW-1:0]    cnt;

    logic [SW-1:0]    shamt;
    logic             is_shift;
    logic [WIDTH-1:0] comb_res;
    logic [WIDTH-1:0] shift_next;
    logic             slt_lt;

    assign shamt    = b[SW-1:0];
    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);
    assign slt_lt   = $signed(a) < $signed(b);

    always_comb begin
        comb_res = '0;
        case (alu_control)
            OP_AND: comb_res = a & b;
            OP_OR:  comb_res = a | b;
            OP_ADD: comb_res = a + b;
            OP_XOR: comb_res = a ^ b;
            OP_SUB: comb_res = a - b;
            OP_SLT: comb_res = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_NOR: comb_res = ~(a | b);
            default: comb_res = '0;
        endcase
    end

    always_comb begin
        shift_next = acc;
        case (op_q)
            OP_SLL:  shift_next = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  shift_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: shift_next = acc;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mul_sum;

    assign mul_sum = mplier[0] ? (acc + mcand) : acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            acc      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cnt      <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand    <= '0;
            mplier   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= alu_control;
                        if (is_shift) begin
                            if (shamt == '0) begin
                                result_q <= a;
                                zero_q   <= (a == '0);
                                state    <= S_DONE;
                            end else begin
                                acc   <= a;
                                cnt   <= {1'b0, shamt};
                                state <= S_SHIFT;
                            end
`ifdef ALU_SEQ_MUL_EN
                        end else if (alu_control == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= a;
                            mplier <= b;
                            cnt    <= CW'(WIDTH);
                            state  <= S_MUL;
`endif
                        end else begin
                            result_q <= comb_res;
                            zero_q   <= (comb_res == '0);
                            state    <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= shift_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_q <= shift_next;
                        zero_q   <= (shift_next == '0);
                        state    <= S_DONE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    // Low bits of the product only; bits shifted out of mcand are dropped.
                    acc    <= mul_sum;
                    mcand  <= {mcand[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_q <= mul_sum;
                        zero_q   <= (mul_sum == '0);
                        state    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq; expected results come from a plain-arithmetic model.
// Define ALU_SEQ_MUL_EN for both bench and RTL to exercise the multiplier build.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   sh;
        sh    = int'(y[4:0]);
        e.lat = 1;
        e.k   = 0;
        case (op)
            4'd0:  e.res = x & y;
            4'd1:  e.res = x | y;
            4'd2:  e.res = x + y;
            4'd3:  e.res = x ^ y;
            4'd4:  begin e.res = x << sh; e.lat = 1 + sh; end
            4'd5:  begin e.res = x >> sh; e.lat = 1 + sh; end
            4'd6:  e.res = x - y;
            4'd7:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8:  begin e.res = 32'($signed(x) >>> sh); e.lat = 1 + sh; end
`ifdef ALU_SEQ_MUL_EN
            4'd9:  begin e.res = x * y; e.lat = 33; end
`endif
            4'd12: e.res = ~(x | y);
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: checks every cycle the DUT presents a result, pops on handshake.
    bit seen = 1'b0;
    bit chk_idle = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen     = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("idle_in_ready", 32'(in_ready), 32'd1);
                chk_idle = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - sb[0].k + 1), 32'(sb[0].lat));
                        seen = 1'b1;
                    end
                    chk("result", result, sb[0].res);
                    chk("zero", 32'(zero), 32'(sb[0].z));
                    chk("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen     = 1'b0;
                        chk_idle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
        bit   accepted;
        int   n;
        exp_t e;
        accepted    = 1'b0;
        n           = 0;
        in_valid    = 1'b1;
        alu_control = op;
        a           = x;
        b           = y;
        while (!accepted && n < 300) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (push) begin
                    e   = model(op, x, y);
                    e.k = cyc + 1;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        a           = $urandom;
        b           = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x, y;
        int          n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        issue(4'd2, 32'd7, 32'd5, 1'b1);
        issue(4'd6, 32'd5, 32'd5, 1'b1);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(4'd7, 32'h8000_0000, 32'd1, 1'b1);
        issue(4'd7, 32'd1, 32'h8000_0000, 1'b1);
        issue(4'd8, 32'h8000_0000, 32'd4, 1'b1);
        issue(4'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(4'd5, 32'hF000_000F, 32'd31, 1'b1);
        issue(4'd9, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        issue(4'd12, 32'h0F0F_0000, 32'h0000_F0F0, 1'b1);
        issue(4'd10, 32'h1234_5678, 32'h1, 1'b1);
        drain();

        // Hold out_ready low for 3 cycles in DONE; monitor checks stability each cycle.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        issue(4'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        drain();

        // Reset during a long shift: nothing must be delivered.
        issue(4'd5, 32'hFFFF_0000, 32'd20, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        issue(4'd2, 32'd7, 32'd5, 1'b1);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                x = 32'($urandom_range(0, 7));
                y = x;
            end
            issue(op, x, y, 1'b1);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
